// File: rtl/multicycle_control.sv
// Main control FSM of the multicycle RISC-V datapath (ld, sd, R-type, beq).
// Moore outputs decoded from the state register; pc_write additionally gated by the ALU zero flag.
module multicycle_control #(
    parameter logic [6:0] OPC_LD    = 7'b0000011,
    parameter logic [6:0] OPC_SD    = 7'b0100011,
    parameter logic [6:0] OPC_RTYPE = 7'b0110011,
    parameter logic [6:0] OPC_BEQ   = 7'b1100011
) (
    input  logic       clk,
    input  logic       rst,
    input  logic [6:0] opcode,
    input  logic       zero,
    output logic       pc_write,
    output logic       adr_src,
    output logic       mem_write,
    output logic       ir_write,
    output logic [1:0] result_src,
    output logic [1:0] alu_src_a,
    output logic [1:0] alu_src_b,
    output logic [1:0] alu_op,
    output logic       reg_write,
    output logic       illegal,
    output logic [3:0] state
);

    typedef enum logic [3:0] {
        S_RST    = 4'd0,
        S_FETCH  = 4'd1,
        S_DECODE = 4'd2,
        S_MEMADR = 4'd3,
        S_MEMRD  = 4'd4,
        S_MEMWB  = 4'd5,
        S_MEMWR  = 4'd6,
        S_EXEC   = 4'd7,
        S_ALUWB  = 4'd8,
        S_BEQ    = 4'd9
    } state_t;

    state_t r_state;
    state_t w_next;
    logic   r_illegal;
    logic   w_pc_update;
    logic   w_branch;
    logic   w_unknown_op;

    assign w_unknown_op = !(opcode inside {OPC_LD, OPC_SD, OPC_RTYPE, OPC_BEQ});

    // NOTE: sequential state uses non-blocking assignments so every register samples pre-edge values.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_state <= S_RST;
        end else begin
            r_state <= w_next;
        end
    end

    // Sticky flag: records that DECODE saw an opcode this controller cannot sequence.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_illegal <= 1'b0;
        end else if (r_state == S_DECODE && w_unknown_op) begin
            r_illegal <= 1'b1;
        end
    end

    always_comb begin
        // NOTE: every output gets a default first so no path through the case infers a latch.
        w_next      = r_state;
        w_pc_update = 1'b0;
        w_branch    = 1'b0;
        adr_src     = 1'b0;
        mem_write   = 1'b0;
        ir_write    = 1'b0;
        result_src  = 2'b00;
        alu_src_a   = 2'b00;
        alu_src_b   = 2'b00;
        alu_op      = 2'b00;
        reg_write   = 1'b0;
        case (r_state)
            S_RST: w_next = S_FETCH;
            S_FETCH: begin
                ir_write    = 1'b1;
                w_pc_update = 1'b1;
                alu_src_b   = 2'b10;
                result_src  = 2'b10;
                w_next      = S_DECODE;
            end
            S_DECODE: begin
                // Branch target PC+imm is precomputed here into ALUOut.
                alu_src_a = 2'b01;
                alu_src_b = 2'b01;
                if (opcode == OPC_LD || opcode == OPC_SD) w_next = S_MEMADR;
                else if (opcode == OPC_RTYPE)             w_next = S_EXEC;
                else if (opcode == OPC_BEQ)               w_next = S_BEQ;
                else                                      w_next = S_FETCH;
            end
            S_MEMADR: begin
                alu_src_a = 2'b10;
                alu_src_b = 2'b01;
                w_next    = (opcode == OPC_SD) ? S_MEMWR : S_MEMRD;
            end
            S_MEMRD: begin
                adr_src = 1'b1;
                w_next  = S_MEMWB;
            end
            S_MEMWB: begin
                result_src = 2'b01;
                reg_write  = 1'b1;
                w_next     = S_FETCH;
            end
            S_MEMWR: begin
                adr_src   = 1'b1;
                mem_write = 1'b1;
                w_next    = S_FETCH;
            end
            S_EXEC: begin
                alu_src_a = 2'b10;
                alu_op    = 2'b10;
                w_next    = S_ALUWB;
            end
            S_ALUWB: begin
                reg_write = 1'b1;
                w_next    = S_FETCH;
            end
            S_BEQ: begin
                alu_src_a = 2'b10;
                alu_op    = 2'b01;
                w_branch  = 1'b1;
                w_next    = S_FETCH;
            end
            default: w_next = S_RST;
        endcase
    end

    assign pc_write = w_pc_update | (w_branch & zero);
    assign illegal  = r_illegal;
    assign state    = r_state;

endmodule
